// File: rtl/gpu_pkg.sv
// Shared GPU scan-out definitions: display geometry, colours and fetch FSM states.
package gpu_pkg;

  localparam int unsigned WIDTH  = 800;
  localparam int unsigned HEIGHT = 600;

  localparam logic [7:0] BLACK_COLOR = 8'hFC;
  localparam logic [7:0] WHITE_COLOR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/line_bank_ram.sv
// Ping-pong line storage: two banks of DEPTH bytes, one write port, one registered read port.
module line_bank_ram #(
  parameter int unsigned DEPTH = 800,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  localparam int unsigned AW = $clog2(2 * DEPTH);

  logic [7:0]    mem [0:2*DEPTH-1];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Bank 1 occupies the upper DEPTH entries; no power-of-two padding between banks.
  always_comb begin
    wr_addr = wr_bank ? AW'(DEPTH) + AW'(wr_idx) : AW'(wr_idx);
    rd_addr = rd_bank ? AW'(DEPTH) + AW'(rd_idx) : AW'(rd_idx);
  end

  // Synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches display lines from framebuffer memory into a ping-pong buffer and serves pixels to scan-out.
module vga_line_fetcher
  import gpu_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = WIDTH,
  parameter int unsigned LINES       = HEIGHT,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [7:0]  BLANK_COLOR = BLACK_COLOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_req,
  output logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              underrun
);

  localparam int unsigned IDX_W  = $clog2(LINE_PIXELS + 1);
  localparam int unsigned LINE_W = $clog2(LINES + 1);

  fetch_state_t      state, state_next;
  logic [IDX_W-1:0]  col;
  logic [IDX_W-1:0]  pix_idx;
  logic [LINE_W-1:0] fill_line;
  logic [ADDR_W-1:0] line_base;
  logic              disp_bank;
  logic              wr_en;
  logic              rd_en;
  logic              more_lines;
  logic              pix_valid;
  logic [7:0]        ram_q;

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, memory request outputs and buffer write/read strobes.
  always_comb begin
    state_next = state;
    more_lines = fill_line < LINE_W'(LINES - 1);
    mem_rd     = (state == REQ);
    mem_addr   = line_base + ADDR_W'(col);
    // An ack coinciding with frame/line start belongs to the abandoned fill.
    wr_en      = (state == REQ) && mem_ack && !frame_start && !line_start;
    rd_en      = pix_req && (pix_idx < IDX_W'(LINE_PIXELS));
    if (frame_start) begin
      state_next = REQ;
    end else if (line_start) begin
      state_next = more_lines ? REQ : IDLE;
    end else if (wr_en && (col == IDX_W'(LINE_PIXELS - 1))) begin
      state_next = DONE;
    end
  end

  // Fill position, line addressing, bank select, display index and underrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      pix_idx   <= '0;
      fill_line <= '0;
      line_base <= '0;
      disp_bank <= 1'b0;
      underrun  <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd_en;
      if (frame_start) begin
        col       <= '0;
        pix_idx   <= '0;
        fill_line <= '0;
        line_base <= '0;
      end else if (line_start) begin
        disp_bank <= ~disp_bank;
        pix_idx   <= '0;
        col       <= '0;
        if (state != DONE) underrun <= 1'b1;
        if (more_lines) begin
          fill_line <= fill_line + 1'b1;
          line_base <= line_base + ADDR_W'(LINE_PIXELS);
        end
      end else begin
        if (wr_en) col <= col + 1'b1;
        if (rd_en) pix_idx <= pix_idx + 1'b1;
      end
    end
  end

  line_bank_ram #(
    .DEPTH(LINE_PIXELS),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (~disp_bank),
    .wr_idx  (col),
    .wr_data (mem_rdata),
    .rd_en   (rd_en),
    .rd_bank (disp_bank),
    .rd_idx  (pix_idx),
    .rd_data (ram_q)
  );

  // The RAM output register carries no reset, so a reset-able valid flag selects blank
  // instead; this keeps pix_data at BLANK_COLOR immediately on reset.
  assign pix_data = pix_valid ? ram_q : BLANK_COLOR;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher: directed frame/line sequences against a byte memory model.
module tb_vga_line_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [7:0]  pix_data;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        underrun;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  dchk_t       dq[$];
  logic [7:0]  pixq[$];
  logic [18:0] addrq[$];
  int          checks = 0;
  int          errors = 0;
  logic        req_d = 1'b0;

  int          lat = 0;
  int          cnt = 0;
  logic [18:0] stop_addr = '1;
  logic        force_ack = 1'b0;

  vga_line_fetcher #(
    .LINE_PIXELS(800),
    .LINES(600),
    .ADDR_W(19),
    .BLANK_COLOR(8'hFC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Memory model: returns addr[7:0] after lat wait cycles; can stall at stop_addr or inject a stray ack.
  always @(posedge clk) begin
    #2;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hAA;
    end else if (mem_rd && mem_addr != stop_addr) begin
      if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr[7:0];
        cnt       = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      cnt     = 0;
    end
  end

  // Remember whether the DUT consumed a pixel request on this edge.
  always @(posedge clk) req_d = pix_req;

  // Monitor: compares presented pixels, acknowledged addresses and queued direct checks.
  always @(negedge clk) begin
    if (req_d) begin
      checks++;
      if (pixq.size() == 0) begin
        errors++;
        $display("FAIL pix_extra: got %02h with no expected pixel queued", pix_data);
      end else begin
        logic [7:0] e;
        e = pixq.pop_front();
        if (pix_data !== e) begin
          errors++;
          $display("FAIL pix_data: got %02h expected %02h", pix_data, e);
        end
      end
    end
    if (mem_rd && mem_ack && addrq.size() > 0) begin
      logic [18:0] a;
      a = addrq.pop_front();
      checks++;
      if (mem_addr !== a) begin
        errors++;
        $display("FAIL mem_addr: got %0d expected %0d", mem_addr, a);
      end
    end
    while (dq.size() > 0) begin
      dchk_t d;
      d = dq.pop_front();
      checks++;
      if (d.act !== d.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", d.name, d.act, d.exp);
      end
    end
  end

  task automatic expect_eq(input string n, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{name: n, act: a, exp: e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_ls();
    tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    int pk;
    int w;

    // Reset values
    #1;
    expect_eq("rst_pix_data", 32'(pix_data), 32'hFC);
    expect_eq("rst_mem_rd", 32'(mem_rd), 0);
    expect_eq("rst_mem_addr", 32'(mem_addr), 0);
    expect_eq("rst_underrun", 32'(underrun), 0);
    tick();
    tick();
    reset = 1'b0;

    // Frame start with zero-wait memory: line 0 walks 0..799, done after 801 cycles
    lat = 0;
    pulse_fs();
    for (int a = 0; a < 800; a++) addrq.push_back(19'(a));
    expect_eq("fs_mem_rd_rise", 32'(mem_rd), 1);
    repeat (799) tick();
    expect_eq("fill0_last_rd", 32'(mem_rd), 1);
    expect_eq("fill0_last_addr", 32'(mem_addr), 799);
    tick();
    expect_eq("fill0_done_rd", 32'(mem_rd), 0);
    expect_eq("fill0_addrq_empty", 32'(addrq.size()), 0);
    expect_eq("idle_pix_blank", 32'(pix_data), 32'hFC);

    // Line start: 802 pixel requests on line 0, next fill from 800
    pulse_ls();
    for (int a = 800; a < 1600; a++) addrq.push_back(19'(a));
    expect_eq("ls_next_addr", 32'(mem_addr), 800);
    for (int i = 0; i < 802; i++) begin
      pix_req = 1'b1;
      pixq.push_back(i < 800 ? 8'(i) : 8'hFC);
      tick();
    end
    pix_req = 1'b0;
    tick();
    expect_eq("noreq_pix_blank", 32'(pix_data), 32'hFC);
    expect_eq("fill1_done_rd", 32'(mem_rd), 0);
    expect_eq("fill1_addrq_empty", 32'(addrq.size()), 0);

    // Slow memory, short lines: underrun on the swap that beats the fill
    lat = 3;
    pulse_ls();
    expect_eq("swap_done_no_underrun", 32'(underrun), 0);
    expect_eq("fill2_start_addr", 32'(mem_addr), 1600);
    repeat (900) tick();
    pulse_ls();
    expect_eq("underrun_set", 32'(underrun), 1);
    expect_eq("fill3_start_addr", 32'(mem_addr), 2400);

    // Underrun survives frame_start; refill line 0, then stall line 1 at 1234
    lat = 0;
    pulse_fs();
    for (int a = 0; a < 800; a++) addrq.push_back(19'(a));
    expect_eq("underrun_sticky_fs", 32'(underrun), 1);
    expect_eq("fs_restart_addr", 32'(mem_addr), 0);
    repeat (801) tick();
    expect_eq("refill0_done_rd", 32'(mem_rd), 0);
    stop_addr = 19'd1234;
    pulse_ls();
    for (int a = 800; a < 1234; a++) addrq.push_back(19'(a));
    pk = 0;
    w  = 0;
    while (!(mem_rd && mem_addr == 19'd1234) && w < 2000) begin
      pix_req = 1'b1;
      pixq.push_back(8'(pk));
      pk++;
      tick();
      w++;
    end
    if (w >= 2000) expect_eq("wait_addr_1234_timeout", 0, 1);
    repeat (2) begin
      pix_req = 1'b1;
      pixq.push_back(8'(pk));
      pk++;
      tick();
    end
    pix_req = 1'b0;
    expect_eq("stall_addr", 32'(mem_addr), 1234);
    expect_eq("stall_rd", 32'(mem_rd), 1);
    expect_eq("stall_addrq_empty", 32'(addrq.size()), 0);
    #6;
    reset = 1'b1;
    #1;
    expect_eq("async_rst_rd", 32'(mem_rd), 0);
    expect_eq("async_rst_pix", 32'(pix_data), 32'hFC);
    expect_eq("async_rst_addr", 32'(mem_addr), 0);
    expect_eq("async_rst_underrun", 32'(underrun), 0);
    tick();
    reset     = 1'b0;
    stop_addr = '1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    expect_eq("late_ack_rd", 32'(mem_rd), 0);
    // Swap to bank 1, which still holds line 1 data from before reset
    pulse_ls();
    pix_req = 1'b1;
    pixq.push_back(8'h20);
    tick();
    pixq.push_back(8'h21);
    tick();
    pix_req = 1'b0;
    tick();

    // Whole frame of line starts: no request after the last line, restart at 0
    pulse_fs();
    for (int n = 1; n < 600; n++) pulse_ls();
    expect_eq("line599_rd", 32'(mem_rd), 1);
    expect_eq("line599_addr", 32'(mem_addr), 599 * 800);
    pulse_ls();
    expect_eq("after_last_rd", 32'(mem_rd), 0);
    pulse_ls();
    tick();
    expect_eq("extra_ls_rd", 32'(mem_rd), 0);
    pulse_fs();
    expect_eq("new_frame_rd", 32'(mem_rd), 1);
    expect_eq("new_frame_addr", 32'(mem_addr), 0);

    tick();
    expect_eq("pixq_drained", 32'(pixq.size()), 0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: stop a run that never reaches the summary.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_line_fetcher.md
# vga_line_fetcher

Upstream feeder for the GPU scan-out stage. Fetches each display line of 8-bit pixels from framebuffer memory over a byte-wide request/acknowledge bus into a ping-pong line buffer. Serves pixels one per clock to the timing generator while the next line fills. Decouples slow or variable-latency VRAM from the fixed 800×600 pixel cadence.

## Interface
- `LINE_PIXELS`, 800: pixels per active line.
- `LINES`, 600: active lines per frame.
- `ADDR_W`, 19: framebuffer byte address width; must satisfy 2^ADDR_W ≥ LINE_PIXELS·LINES.
- `BLANK_COLOR`, 8'hFC: pixel value driven when no valid pixel is available.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse, first cycle of vertical sync.
- `line_start` in 1: one-cycle pulse, start of horizontal sync of each line.
- `pix_req` in 1: timing generator consumes one pixel this cycle.
- `pix_data` out 8: pixel, registered, valid the cycle after `pix_req`.
- `mem_addr` out ADDR_W: framebuffer byte address.
- `mem_rd` out 1: read request; held until acknowledged.
- `mem_rdata` in 8: read data, valid when `mem_ack`.
- `mem_ack` in 1: one-cycle acknowledge of the outstanding read.
- `underrun` out 1: sticky; set when a bank swap occurs before the fill completes.

## Operation
- Two banks of `LINE_PIXELS` bytes each: `disp_bank` (read by scan-out) and `fill_bank` (written by the fetcher), with `fill_bank = ~disp_bank`.
- Fetch FSM:
  - IDLE: no read outstanding.
  - REQ: drive `mem_rd=1`, `mem_addr = line_base + col`.
  - On `mem_ack`: write `mem_rdata` to fill bank at `col`, `col++`. If `col == LINE_PIXELS-1`, go to DONE; otherwise stay in REQ with the next address. Back-to-back requests are allowed.
  - DONE: hold until the next swap.
- `frame_start`:
  - `line_base ← 0`, `fill_line ← 0`.
  - Abort any fill in progress; an ack arriving in the same cycle is discarded.
  - Start filling line 0 into the current `fill_bank` (REQ, `col=0`).
  - Clear the display index; do not clear `underrun`.
- `line_start`:
  - Swap banks and reset `pix_idx ← 0`.
  - If the FSM was not in DONE, set `underrun`.
  - If `fill_line < LINES-1`: `fill_line++`, `line_base += LINE_PIXELS`, start the next fill (REQ, `col=0`). Otherwise go to IDLE.
- If `frame_start` and `line_start` arrive in the same cycle, `frame_start` wins and no swap occurs.
- Pixel path on `pix_req`:
  - `pix_data ← disp_bank[pix_idx]` if `pix_idx < LINE_PIXELS`, otherwise `BLANK_COLOR`.
  - `pix_idx` saturates at `LINE_PIXELS`.
  - Without `pix_req`, `pix_data` becomes `BLANK_COLOR`.
- Arithmetic:
  - `line_base` is ADDR_W bits. It never exceeds (LINES-1)·LINE_PIXELS, so no wrap occurs.
  - `col` and `pix_idx` are 10 bits for the defaults, sized as clog2(LINE_PIXELS+1).
- `underrun` is cleared only by `reset`.

## Timing
- Reset values:
  - Outputs: `pix_data=BLANK_COLOR`, `mem_rd=0`, `mem_addr=0`, `underrun=0`.
  - Internal: FSM IDLE, `disp_bank=0`, `pix_idx=0`, `line_base=0`.
- Reset mid-fetch drops `mem_rd` immediately (asynchronous); a later `mem_ack` is ignored in IDLE.
- `mem_rd` rises the cycle after `frame_start` or `line_start`.
- `mem_addr` is stable while `mem_rd=1` and `mem_ack=0`.
- Pixel latency: one clock from `pix_req` to `pix_data`.
- The first `pix_req` may occur the cycle after `line_start`.
- Full line fill needs ≥ LINE_PIXELS ack cycles. With zero-wait memory it completes in LINE_PIXELS+1 cycles after the start.

## Structure
- Shared package `gpu_pkg`: `BLACK_COLOR` (8'hFC), `WHITE_COLOR`, `WIDTH`, `HEIGHT`, and the fetch FSM enum `fetch_state_t {IDLE, REQ, DONE}`.
- Sub-module `line_bank_ram`:
  - Simple dual-port, 2·LINE_PIXELS × 8.
  - One write port addressed by {fill_bank, col}.
  - One registered read port addressed by {disp_bank, pix_idx}.

## Test plan
- Reset, then `frame_start`, zero-wait memory returning `addr[7:0]` → `mem_addr` walks 0..799, then `mem_rd=0` and FSM in DONE after 801 cycles.
- `line_start`, then 800 `pix_req` cycles → `pix_data` = 0x00,0x01,…,0x1F (wrapping per `addr[7:0]`); the next fill starts at `mem_addr=800`.
- 801st `pix_req` on a line → `pix_data=8'hFC`; no `pix_req` → 8'hFC.
- Memory with 3-cycle ack latency and `line_start` only 900 cycles apart → `underrun=1` after the first swap, remaining set until reset.
- Run 600 lines, then extra `line_start` pulses → no `mem_rd` after line 599 fill; the next `frame_start` restarts at `mem_addr=0`.
- Assert `reset` while `mem_rd=1` at `mem_addr=1234` → `mem_rd=0` and `pix_data=8'hFC` same cycle; a late `mem_ack` writes nothing.
